// File: rtl/rvfi_lane_serializer.sv
// rvfi_lane_serializer: compacts up to LANES RVFI retirements per cycle into a
// FIFO and replays them one per cycle to a single-lane consumer. It tracks
// halt/trap and raises sticky fault bits on errcode:
//   [0] order mismatch (only built with RVFI_ORDER_CHECK_EN)
//   [1] commit while in_ready=0 (bundle dropped)
//   [2] lanes above an accepted halt dropped
//   [3] trap record delivered
// Optional feature macro: RVFI_ORDER_CHECK_EN.

// Per-lane acceptance stage. The lanes form a chain in ascending index order:
// blk carries "a lower accepted lane halted", off carries the slot offset.
module rvfi_ser_lane #(
  parameter int CNT_W = 5
) (
  input  logic             commit_i,
  input  logic             halt_i,
  input  logic             blk_i,
  input  logic [CNT_W-1:0] off_i,
  output logic             acc_o,
  output logic             drop_o,
  output logic             blk_o,
  output logic [CNT_W-1:0] off_o
);
  assign acc_o  = commit_i & ~blk_i;
  assign drop_o = commit_i & blk_i;
  assign blk_o  = blk_i | (acc_o & halt_i);
  assign off_o  = off_i + CNT_W'(acc_o);
endmodule

module rvfi_lane_serializer #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int PKT_W = 199
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_commit,
  input  logic [LANES*PKT_W-1:0] in_pkt,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       out_pkt,
  output logic                   halted,
  output logic [15:0]            errcode
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [3:0]             err_q, err_d;
  logic [PKT_W-1:0]       mem [DEPTH];

  logic [LANES:0]             blk;
  logic [LANES:0][CNT_W-1:0]  off;
  logic [LANES-1:0]           acc, drop;

  logic [PKT_W-1:0] head;
  logic             head_halt, head_trap;
  logic [CNT_W-1:0] space;
  logic             push, pop, order_err;

  assign blk[0] = 1'b0;
  assign off[0] = '0;

  // lane chain: lane i lands at wptr + (accepted lanes below i)
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rvfi_ser_lane #(.CNT_W(CNT_W)) u_lane (
      .commit_i (in_commit[g]),
      .halt_i   (in_pkt[g*PKT_W]),
      .blk_i    (blk[g]),
      .off_i    (off[g]),
      .acc_o    (acc[g]),
      .drop_o   (drop[g]),
      .blk_o    (blk[g+1]),
      .off_o    (off[g+1])
    );
  end

  assign head      = mem[rptr_q];
  assign head_halt = head[0];
  assign head_trap = head[1];

  // readiness uses registered count only; a same-cycle pop never helps
  assign space     = CNT_W'(DEPTH) - count_q;
  assign in_ready  = (state_q == S_RUN) && (space >= CNT_W'(LANES));
  assign out_valid = (count_q != '0) && (state_q != S_DONE);
  assign out_pkt   = out_valid ? head : '0;
  assign halted    = (state_q == S_DONE);
  assign errcode   = {12'b0, err_q};

  assign push = in_ready && (|in_commit);
  assign pop  = out_valid && out_ready;

`ifdef RVFI_ORDER_CHECK_EN
  logic [63:0] exp_q, exp_d;
  logic [63:0] head_order;
  assign head_order = head[PKT_W-1 -: 64];
  assign order_err  = pop && (head_order != exp_q);
  // expected order follows the stream and resyncs to popped order+1
  assign exp_d      = pop ? head_order + 64'd1 : exp_q;

  // expected-order register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exp_q <= '0;
    else      exp_q <= exp_d;
  end
`else
  assign order_err = 1'b0;
`endif

  // next-state: FSM, pointers, occupancy and sticky faults
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_RUN:   if (push && blk[LANES]) state_d = S_DRAIN;
      S_DRAIN: if (pop && head_halt)   state_d = S_DONE;
      default: state_d = state_q;
    endcase
    if (push) wptr_d = wptr_q + PTR_W'(off[LANES]);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    count_d = count_q + (push ? off[LANES] : '0) - (pop ? CNT_W'(1) : '0);
    err_d[0] = err_q[0] | order_err;
    err_d[1] = err_q[1] | ((|in_commit) && !in_ready);
    err_d[2] = err_q[2] | (push && (|drop));
    err_d[3] = err_q[3] | (pop && head_trap);
  end

  // control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // FIFO storage: accepted lanes written to consecutive slots, gaps skipped
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push && acc[i]) mem[wptr_q + PTR_W'(off[i])] <= in_pkt[i*PKT_W +: PKT_W];
    end
  end
endmodule

// File: tb/tb_rvfi_lane_serializer.sv
// Directed bench for rvfi_lane_serializer (default LANES=4, DEPTH=16).
module tb_rvfi_lane_serializer;
  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int PKT_W = 199;
`ifdef RVFI_ORDER_CHECK_EN
  localparam logic OC = 1'b1;
`else
  localparam logic OC = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES-1:0]       in_commit;
  logic [LANES*PKT_W-1:0] in_pkt;
  logic                   in_ready, out_valid, out_ready, halted;
  logic [PKT_W-1:0]       out_pkt;
  logic [15:0]            errcode;

  int nvec = 0;
  int nmis = 0;

  rvfi_lane_serializer #(.LANES(LANES), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk(clk), .rst(rst), .in_commit(in_commit), .in_pkt(in_pkt),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt(out_pkt), .halted(halted), .errcode(errcode)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mk(input logic [63:0] ord, input logic [31:0] inst,
                                          input logic trap, input logic halt);
    return {ord, inst, inst ^ 32'hA5A5_0000, inst + 32'd4, inst[4:0], ~inst, trap, halt};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic setlane(input int i, input logic [PKT_W-1:0] p);
    in_pkt[i*PKT_W +: PKT_W] = p;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] ord);
    chk({tag, "_valid"}, 256'(out_valid), 256'(1));
    chk({tag, "_order"}, 256'(out_pkt[PKT_W-1 -: 64]), 256'(ord));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  256'(in_ready),  256'(1));
    chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    chk({tag, "_out_pkt"},   256'(out_pkt),   256'(0));
    chk({tag, "_halted"},    256'(halted),    256'(0));
    chk({tag, "_errcode"},   256'(errcode),   256'(0));
  endtask

  initial begin
    rst = 1'b0; in_commit = '0; in_pkt = '0; out_ready = 1'b0;
    #12;
    chk_reset_outs("reset");
    rst = 1'b1;
    cyc;

    // full bundle, orders 0..3, streamed out one per cycle
    for (int i = 0; i < 4; i++) setlane(i, mk(64'(i), 32'h100 + 32'(i), 1'b0, 1'b0));
    in_commit = 4'b1111; out_ready = 1'b1;
    chk("t1_no_bypass", 256'(out_valid), 256'(0));
    cyc;
    in_commit = '0;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("t1_pop%0d", i), 64'(i));
      cyc;
    end
    chk("t1_empty", 256'(out_valid), 256'(0));
    chk("t1_err", 256'(errcode), 256'(0));

    // sparse bundle 1010: lane1 then lane3, lanes 0/2 carry decoy data
    setlane(0, mk(64'd99, 32'hDEAD, 1'b0, 1'b0));
    setlane(1, mk(64'd4, 32'h11, 1'b0, 1'b0));
    setlane(2, mk(64'd98, 32'hBEEF, 1'b0, 1'b0));
    setlane(3, mk(64'd5, 32'h33, 1'b0, 1'b0));
    in_commit = 4'b1010;
    cyc;
    in_commit = '0;
    chk("t2_lane1", 256'(out_pkt), 256'(mk(64'd4, 32'h11, 1'b0, 1'b0)));
    cyc;
    chk("t2_lane3", 256'(out_pkt), 256'(mk(64'd5, 32'h33, 1'b0, 1'b0)));
    cyc;
    chk("t2_empty", 256'(out_valid), 256'(0));

    // fill FIFO with four bundles (orders 6..21), consumer stalled
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) setlane(i, mk(64'(6 + 4*b + i), 32'h200 + 32'(4*b + i), 1'b0, 1'b0));
      in_commit = 4'b1111;
      cyc;
      in_commit = '0;
      chk($sformatf("t3_in_ready_b%0d", b), 256'(in_ready), 256'(b < 3 ? 1 : 0));
    end
    for (int i = 0; i < 4; i++) setlane(i, mk(64'(22 + i), 32'h300, 1'b0, 1'b0));
    in_commit = 4'b1111;
    cyc;
    in_commit = '0;
    chk("t3_overflow_err", 256'(errcode), 256'(16'h0002));
    chk_head("t3_head", 64'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_head($sformatf("t3_drain%0d", i), 64'(6 + i));
      cyc;
    end
    chk("t3_count_16", 256'(out_valid), 256'(0));

    // trap record is delivered and flags errcode[3] on pop
    setlane(0, mk(64'd22, 32'h400, 1'b1, 1'b0));
    in_commit = 4'b0001;
    cyc;
    in_commit = '0;
    chk("t4_trap_out", 256'(out_pkt), 256'(mk(64'd22, 32'h400, 1'b1, 1'b0)));
    chk("t4_err_pre", 256'(errcode), 256'(16'h0002));
    cyc;
    chk("t4_err_post", 256'(errcode), 256'(16'h000A));

    // halt on lane1, lanes 2/3 dropped
    out_ready = 1'b0;
    setlane(0, mk(64'd23, 32'h500, 1'b0, 1'b0));
    setlane(1, mk(64'd24, 32'h501, 1'b0, 1'b1));
    setlane(2, mk(64'd25, 32'h502, 1'b0, 1'b0));
    setlane(3, mk(64'd26, 32'h503, 1'b0, 1'b0));
    in_commit = 4'b1111;
    cyc;
    in_commit = '0;
    chk("t5_in_ready", 256'(in_ready), 256'(0));
    chk("t5_err", 256'(errcode), 256'(16'h000E));
    chk_head("t5_head0", 64'd23);
    out_ready = 1'b1;
    cyc;
    chk_head("t5_head1", 64'd24);
    chk("t5_not_halted", 256'(halted), 256'(0));
    cyc;
    chk("t5_halted", 256'(halted), 256'(1));
    chk("t5_valid", 256'(out_valid), 256'(0));
    chk("t5_pkt", 256'(out_pkt), 256'(0));
    chk("t5_in_ready_after", 256'(in_ready), 256'(0));

    // reset out of DONE
    rst = 1'b0;
    #1;
    chk_reset_outs("reset_done");
    cyc;
    rst = 1'b1;
    cyc;

    // order check: 0,1,5 then 6
    setlane(0, mk(64'd0, 32'h600, 1'b0, 1'b0));
    setlane(1, mk(64'd1, 32'h601, 1'b0, 1'b0));
    setlane(2, mk(64'd5, 32'h602, 1'b0, 1'b0));
    setlane(3, mk(64'd77, 32'h603, 1'b0, 1'b0));
    in_commit = 4'b0111; out_ready = 1'b1;
    cyc;
    in_commit = '0;
    chk_head("t6_o0", 64'd0);
    cyc;
    chk_head("t6_o1", 64'd1);
    cyc;
    chk_head("t6_o5", 64'd5);
    chk("t6_err_pre", 256'(errcode), 256'(0));
    setlane(0, mk(64'd6, 32'h604, 1'b0, 1'b0));
    in_commit = 4'b0001;
    cyc;
    in_commit = '0;
    chk("t6_err_post5", 256'(errcode), 256'({OC}));
    chk_head("t6_o6", 64'd6);
    cyc;
    chk("t6_err_post6", 256'(errcode), 256'({OC}));
    chk("t6_empty", 256'(out_valid), 256'(0));

    // mid-stream asynchronous reset
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) setlane(i, mk(64'(7 + i), 32'h700, 1'b0, 1'b0));
    in_commit = 4'b1111;
    cyc;
    in_commit = '0;
    chk_head("t7_pre", 64'd7);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_outs("reset_mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
